// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multiply/divide sequencer and its arbiter.
//   DEF_W   : default operand/result width
//   op_e    : operation encoding used on op0/op1/eng_op (OP_MUL = 0, OP_DIV = 1)
//   state_e : sequencer FSM states
//   DIV0_LO : quotient returned for a divide by zero (all ones)
package muldiv_pkg;

  localparam int DEF_W = 32;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [DEF_W-1:0] DIV0_LO = '1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin picker. Purely combinational; the parent keeps
//   last_gnt and updates it when a response is delivered.
//   req[1:0] : in  - request lines from port 1 / port 0
//   last_gnt : in  - id of the port served most recently
//   gnt_id   : out - id of the selected port (valid when any = 1)
//   any      : out - at least one request is pending
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_id,
  output logic       any
);

  // On a tie the port that was not served last wins; otherwise the only
  // requester wins.
  always_comb begin
    any    = |req;
    gnt_id = (&req) ? ~last_gnt : req[1];
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter
//   Sequencer and two-port round-robin arbiter for a shared multi-cycle
//   MULT/DIV engine. Short-circuits divide-by-zero and exact repeats of the
//   last engine result without starting the engine.
//   clk, rst               : clock, synchronous active-high reset
//   req0/1, op0/1          : request and operation (0 = MULT, 1 = DIV) per port
//   a0, b0, a1, b1         : operands per port (DIV computes a / b)
//   rsp_valid0/1           : one-cycle response pulse per port
//   rsp_hi, rsp_lo         : shared result {hi, lo}, held between responses
//   busy                   : sequencer is not in IDLE
//   eng_start, eng_op      : engine start pulse and operation select
//   eng_a, eng_b           : latched operands to the engine
//   eng_done               : engine completion pulse
//   eng_hi, eng_lo         : engine result, valid with eng_done
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0,
  input  logic         op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  output logic [W-1:0] rsp_hi,
  output logic [W-1:0] rsp_lo,
  output logic         busy,
  output logic         eng_start,
  output logic         eng_op,
  output logic [W-1:0] eng_a,
  output logic [W-1:0] eng_b,
  input  logic         eng_done,
  input  logic [W-1:0] eng_hi,
  input  logic [W-1:0] eng_lo
);

  localparam logic [W-1:0] DIV0_RES = {W{DIV0_LO[0]}};

  state_e       state, state_nxt;
  logic         last_gnt;
  logic         id, id_nxt;
  logic         gnt_id, gnt_any;
  logic         sel_op;
  logic [W-1:0] sel_a, sel_b;
  logic         hit, div0;

  logic         cache_valid;
  logic         cache_op;
  logic [W-1:0] cache_a, cache_b, cache_hi, cache_lo;

  rr_arbiter2 u_arb (
    .req      ({req1, req0}),
    .last_gnt (last_gnt),
    .gnt_id   (gnt_id),
    .any      (gnt_any)
  );

  // Operand selection for the winner, short-circuit detection, and the
  // next-state logic. The cache hit takes priority over divide-by-zero.
  always_comb begin
    sel_op    = gnt_id ? op1 : op0;
    sel_a     = gnt_id ? a1  : a0;
    sel_b     = gnt_id ? b1  : b0;
    hit       = cache_valid && (sel_op == cache_op) &&
                (sel_a == cache_a) && (sel_b == cache_b);
    div0      = (sel_op == OP_DIV) && (sel_b == '0);
    state_nxt = state;
    id_nxt    = id;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          id_nxt    = gnt_id;
          state_nxt = (hit || div0) ? RESP : ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand/result latches and outputs. Every output is a flop
  // loaded from next-state values so it lines up with the state it marks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      id          <= 1'b0;
      last_gnt    <= 1'b1;
      cache_valid <= 1'b0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      eng_op      <= OP_MUL;
      eng_a       <= '0;
      eng_b       <= '0;
      rsp_valid0  <= 1'b0;
      rsp_valid1  <= 1'b0;
      rsp_hi      <= '0;
      rsp_lo      <= '0;
    end else begin
      state      <= state_nxt;
      id         <= id_nxt;
      busy       <= (state_nxt != IDLE);
      eng_start  <= (state_nxt == ISSUE);
      rsp_valid0 <= (state_nxt == RESP) && !id_nxt;
      rsp_valid1 <= (state_nxt == RESP) &&  id_nxt;
      if (state == IDLE && gnt_any) begin
        eng_op <= sel_op;
        eng_a  <= sel_a;
        eng_b  <= sel_b;
        if (hit) begin
          rsp_hi <= cache_hi;
          rsp_lo <= cache_lo;
        end else if (div0) begin
          rsp_hi <= sel_a;
          rsp_lo <= DIV0_RES;
        end
      end
      if (state == WAIT && eng_done) begin
        rsp_hi      <= eng_hi;
        rsp_lo      <= eng_lo;
        cache_valid <= 1'b1;
      end
      if (state == RESP) begin
        last_gnt <= id;
      end
    end
  end

  // Cache payload only matters while cache_valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == WAIT && eng_done) begin
      cache_op <= eng_op;
      cache_a  <= eng_a;
      cache_b  <= eng_b;
      cache_hi <= eng_hi;
      cache_lo <= eng_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter
//   Self-checking bench for muldiv_arbiter with a behavioural engine that
//   pulses done ENG_N cycles after start. Expected responses are queued when
//   a request is driven and compared when the DUT responds.
module tb_muldiv_arbiter;

  localparam int W     = 32;
  localparam int ENG_N = 33;

  typedef struct packed {
    logic         port;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         rsp_valid0, rsp_valid1, busy, eng_start, eng_op;
  logic [W-1:0] rsp_hi, rsp_lo, eng_a, eng_b;
  logic         model_done = 1'b0, spur_done = 1'b0;
  logic [W-1:0] eng_hi = '0, eng_lo = '0;
  wire          eng_done = model_done | spur_done;

  int   cyc = 0, starts = 0, eng_cnt = -1;
  int   n_checks = 0, n_fail = 0;
  exp_t exp_q[$];

  muldiv_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .op0        (op0),
    .op1        (op1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .rsp_valid0 (rsp_valid0),
    .rsp_valid1 (rsp_valid1),
    .rsp_hi     (rsp_hi),
    .rsp_lo     (rsp_lo),
    .busy       (busy),
    .eng_start  (eng_start),
    .eng_op     (eng_op),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_hi     (eng_hi),
    .eng_lo     (eng_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (eng_start) starts++;

  // Engine model: latches operands on eng_start, pulses done ENG_N cycles later.
  always @(posedge clk) begin
    longint prod;
    int     sa, sb;
    #1;
    model_done = 1'b0;
    if (rst) begin
      eng_cnt = -1;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          model_done = 1'b1;
          eng_cnt    = -1;
        end
      end
      if (eng_start) begin
        sa = eng_a;
        sb = eng_b;
        if (eng_op == 1'b0) begin
          prod   = longint'(sa) * longint'(sb);
          eng_hi = prod[63:32];
          eng_lo = prod[31:0];
        end else if (sb != 0) begin
          eng_hi = sa % sb;
          eng_lo = sa / sb;
        end else begin
          eng_hi = '0;
          eng_lo = '0;
        end
        eng_cnt = ENG_N;
      end
    end
  end

  // Waits up to budget negedges for a response; reports what was seen.
  task automatic wait_rsp(input int budget, output bit got, output logic port,
                          output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output int at);
    got = 1'b0; port = 1'b0; hi = '0; lo = '0; at = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (rsp_valid0 || rsp_valid1) begin
        got  = 1'b1;
        port = rsp_valid1;
        hi   = rsp_hi;
        lo   = rsp_lo;
        at   = cyc;
      end
    end
  endtask

  // Advances to a negedge inside an IDLE cycle.
  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rsp_valid0, rsp_valid1, busy, eng_start, eng_op} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b required 00000",
               {rsp_valid0, rsp_valid1, busy, eng_start, eng_op});
    end
    n_checks++;
    if ({rsp_hi, rsp_lo} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rsp: got %h_%h required 0", rsp_hi, rsp_lo);
    end
    n_checks++;
    if ({eng_a, eng_b} !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_eng: got %h_%h required 0", eng_a, eng_b);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_mult();
    bit got; logic p; logic [W-1:0] hi, lo; int at, c0, s0; exp_t e;
    wait_idle();
    c0 = cyc; s0 = starts;
    req0 = 1'b1; op0 = 1'b0; a0 = 32'd7; b0 = 32'hFFFFFFFD;
    exp_q.push_back(exp_t'({1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}));
    wait_rsp(60, got, p, hi, lo, at);
    req0 = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL mult_timeout: no response, required port %0d", e.port);
    end else begin
      n_checks++;
      if ({p, hi, lo} !== {e.port, e.hi, e.lo}) begin
        n_fail++;
        $display("[TB] FAIL mult_data: got p%0d %h_%h required p%0d %h_%h",
                 p, hi, lo, e.port, e.hi, e.lo);
      end
      n_checks++;
      if (at != c0 + ENG_N + 2) begin
        n_fail++;
        $display("[TB] FAIL mult_latency: got %0d required %0d", at - c0, ENG_N + 2);
      end
    end
    n_checks++;
    if (starts - s0 != 1) begin
      n_fail++;
      $display("[TB] FAIL mult_starts: got %0d required 1", starts - s0);
    end
  endtask

  task automatic test_div_zero();
    bit got; logic p; logic [W-1:0] hi, lo; int at, c0, s0; exp_t e;
    wait_idle();
    c0 = cyc; s0 = starts;
    req1 = 1'b1; op1 = 1'b1; a1 = 32'h1234; b1 = 32'h0;
    exp_q.push_back(exp_t'({1'b1, 32'h00001234, 32'hFFFFFFFF}));
    wait_rsp(5, got, p, hi, lo, at);
    req1 = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL div0_timeout: no response, required port %0d", e.port);
    end else begin
      n_checks++;
      if ({p, hi, lo} !== {e.port, e.hi, e.lo}) begin
        n_fail++;
        $display("[TB] FAIL div0_data: got p%0d %h_%h required p%0d %h_%h",
                 p, hi, lo, e.port, e.hi, e.lo);
      end
      n_checks++;
      if (at != c0 + 1) begin
        n_fail++;
        $display("[TB] FAIL div0_latency: got %0d required 1", at - c0);
      end
    end
    n_checks++;
    if (starts != s0) begin
      n_fail++;
      $display("[TB] FAIL div0_starts: got %0d required 0", starts - s0);
    end
  endtask

  task automatic test_cache_hit();
    bit got; logic p; logic [W-1:0] hi, lo; int at, c0, s0; exp_t e;
    logic [W-1:0] bv[3], ehi[3], elo[3];
    int lat[3], nst[3];
    bv  = '{32'd5, 32'd5, 32'd6};
    ehi = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFB};
    elo = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFE};
    lat = '{ENG_N + 2, 1, ENG_N + 2};
    nst = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      wait_idle();
      c0 = cyc; s0 = starts;
      req0 = 1'b1; op0 = 1'b1; a0 = 32'hFFFFFFEF; b0 = bv[k];
      exp_q.push_back(exp_t'({1'b0, ehi[k], elo[k]}));
      wait_rsp(60, got, p, hi, lo, at);
      req0 = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("[TB] FAIL cache_timeout[%0d]: no response", k);
      end else begin
        n_checks++;
        if ({p, hi, lo} !== {e.port, e.hi, e.lo}) begin
          n_fail++;
          $display("[TB] FAIL cache_data[%0d]: got p%0d %h_%h required p%0d %h_%h",
                   k, p, hi, lo, e.port, e.hi, e.lo);
        end
        n_checks++;
        if (at - c0 != lat[k]) begin
          n_fail++;
          $display("[TB] FAIL cache_latency[%0d]: got %0d required %0d", k, at - c0, lat[k]);
        end
      end
      n_checks++;
      if (starts - s0 != nst[k]) begin
        n_fail++;
        $display("[TB] FAIL cache_starts[%0d]: got %0d required %0d", k, starts - s0, nst[k]);
      end
    end
  endtask

  task automatic test_contention();
    bit got; logic p; logic [W-1:0] hi, lo; int at, k0, k1; exp_t e;
    logic [W-1:0] pa[2], pb[2], qa[2], qb[2];
    logic         po[2], qo[2];
    exp_t         pe[2], qe[2];
    pa = '{32'd3, 32'd100};        pb = '{32'd4, 32'd200};  po = '{1'b0, 1'b0};
    qa = '{32'hFFFFFFFB, 32'd100}; qb = '{32'd6, 32'd7};    qo = '{1'b0, 1'b1};
    pe = '{exp_t'({1'b0, 32'h0, 32'd12}), exp_t'({1'b0, 32'h0, 32'd20000})};
    qe = '{exp_t'({1'b1, 32'hFFFFFFFF, 32'hFFFFFFE2}), exp_t'({1'b1, 32'd2, 32'd14})};
    exp_q.delete();
    rst = 1'b1;
    req0 = 1'b1; op0 = po[0]; a0 = pa[0]; b0 = pb[0];
    req1 = 1'b1; op1 = qo[0]; a1 = qa[0]; b1 = qb[0];
    exp_q.push_back(pe[0]);
    exp_q.push_back(qe[0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k0 = 0; k1 = 0;
    for (int n = 0; n < 4; n++) begin
      wait_rsp(60, got, p, hi, lo, at);
      n_checks++;
      if (!got || exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL contention_rsp[%0d]: got=%0d pending=%0d required a queued response",
                 n, got, exp_q.size());
        break;
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({p, hi, lo} !== {e.port, e.hi, e.lo}) begin
        n_fail++;
        $display("[TB] FAIL contention_data[%0d]: got p%0d %h_%h required p%0d %h_%h",
                 n, p, hi, lo, e.port, e.hi, e.lo);
      end
      if (p == 1'b0) begin
        k0++;
        if (k0 < 2) begin
          op0 = po[k0]; a0 = pa[k0]; b0 = pb[k0];
          exp_q.push_back(pe[k0]);
        end else req0 = 1'b0;
      end else begin
        k1++;
        if (k1 < 2) begin
          op1 = qo[k1]; a1 = qa[k1]; b1 = qb[k1];
          exp_q.push_back(qe[k1]);
        end else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_wait();
    bit got, seen; logic p; logic [W-1:0] hi, lo; int at, s0; exp_t e;
    wait_idle();
    req0 = 1'b1; op0 = 1'b0; a0 = 32'd11; b0 = 32'd13;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
    req0 = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL abort_start: eng_start not seen, required within 2 cycles");
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, rsp_valid0, rsp_valid1} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL abort_busy: got %b required 000", {busy, rsp_valid0, rsp_valid1});
    end
    rst = 1'b0;
    wait_rsp(45, got, p, hi, lo, at);
    n_checks++;
    if (got) begin
      n_fail++;
      $display("[TB] FAIL abort_rsp: got response p%0d, required none", p);
    end
    // Previously cached tuple first (cache must be empty), then the aborted one.
    for (int k = 0; k < 2; k++) begin
      wait_idle();
      s0 = starts;
      if (k == 0) begin
        req1 = 1'b1; op1 = 1'b1; a1 = 32'd100; b1 = 32'd7;
        exp_q.push_back(exp_t'({1'b1, 32'd2, 32'd14}));
      end else begin
        req0 = 1'b1; op0 = 1'b0; a0 = 32'd11; b0 = 32'd13;
        exp_q.push_back(exp_t'({1'b0, 32'd0, 32'd143}));
      end
      wait_rsp(60, got, p, hi, lo, at);
      req0 = 1'b0; req1 = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("[TB] FAIL reissue_timeout[%0d]: no response", k);
      end else if ({p, hi, lo} !== {e.port, e.hi, e.lo}) begin
        n_fail++;
        $display("[TB] FAIL reissue_data[%0d]: got p%0d %h_%h required p%0d %h_%h",
                 k, p, hi, lo, e.port, e.hi, e.lo);
      end
      n_checks++;
      if (starts - s0 != 1) begin
        n_fail++;
        $display("[TB] FAIL reissue_starts[%0d]: got %0d required 1", k, starts - s0);
      end
    end
  endtask

  task automatic test_spurious_done();
    bit got; logic p; logic [W-1:0] hi, lo; int at, s0;
    wait_idle();
    s0 = starts;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    wait_rsp(6, got, p, hi, lo, at);
    n_checks++;
    if (got || busy !== 1'b0 || starts != s0) begin
      n_fail++;
      $display("[TB] FAIL spurious: got rsp=%0d busy=%b starts=%0d required 0 0 0",
               got, busy, starts - s0);
    end
    n_checks++;
    if ({rsp_hi, rsp_lo} !== {32'd0, 32'd143}) begin
      n_fail++;
      $display("[TB] FAIL rsp_hold: got %h_%h required 00000000_0000008f", rsp_hi, rsp_lo);
    end
  endtask

  task automatic test_back_to_back();
    bit got; logic p; logic [W-1:0] hi, lo; int at, c0, s0, want; exp_t e;
    wait_idle();
    c0 = cyc; s0 = starts; want = c0 + ENG_N + 2;
    req0 = 1'b1; op0 = 1'b0; a0 = 32'hFFFFFC18; b0 = 32'd1000;
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_t'({1'b0, 32'hFFFFFFFF, 32'hFFF0BDC0}));
    for (int k = 0; k < 3; k++) begin
      wait_rsp(60, got, p, hi, lo, at);
      if (k == 2) req0 = 1'b0;
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("[TB] FAIL b2b_timeout[%0d]: no response", k);
        break;
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({p, hi, lo} !== {e.port, e.hi, e.lo} || at != want) begin
        n_fail++;
        $display("[TB] FAIL b2b[%0d]: got p%0d %h_%h @%0d required p%0d %h_%h @%0d",
                 k, p, hi, lo, at, e.port, e.hi, e.lo, want);
      end
      want = at + 2;
    end
    req0 = 1'b0;
    exp_q.delete();
    n_checks++;
    if (starts - s0 != 1) begin
      n_fail++;
      $display("[TB] FAIL b2b_starts: got %0d required 1", starts - s0);
    end
  endtask

  // Global time bound so a stuck DUT still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_mult();
    test_div_zero();
    test_cache_hit();
    test_contention();
    test_reset_mid_wait();
    test_spurious_done();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Sequencer and two-port arbiter for the shared multi-cycle multiply/divide engine. The block accepts signed MULT/DIV requests from two requesters (port 0: integer pipeline, port 1: coprocessor/debug path) and grants them round-robin. It drives the engine's start/done handshake and returns the {HI, LO} result to the winning port. It also short-circuits divide-by-zero and exact repeats of the last completed operation without starting the engine.

## Interface
- W, 32, operand/result width
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req0, req1  in  1  request; held high with operands stable until matching rsp_valid
- op0, op1  in  1  0 = MULT, 1 = DIV
- a0, b0, a1, b1  in  W  operands (DIV: a / b)
- rsp_valid0, rsp_valid1  out  1  one-cycle response pulse to port 0/1
- rsp_hi, rsp_lo  out  W  result, shared, valid with rsp_valid*; MULT {hi,lo} = 64-bit product, DIV hi = remainder, lo = quotient
- busy  out  1  high in any state other than IDLE
- eng_start  out  1  one-cycle start pulse to engine
- eng_op  out  1  operation select to engine
- eng_a, eng_b  out  W  latched operands, stable from eng_start until eng_done
- eng_done  in  1  one-cycle completion pulse from engine
- eng_hi, eng_lo  in  W  engine result, valid with eng_done

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Sample req0 and req1.
  - If only one is high, pick it. If both are high, pick the port not granted last (last_gnt resets to 1, so port 0 wins the first tie).
  - Latch op, a, b and the winning id.
  - Then, in priority order:
    - Cache hit (cache_valid, and op, a, b equal the cached tuple): load the cached result, go to RESP.
    - DIV with b == 0: result hi = a, lo = all ones. Go to RESP. Cache is not updated.
    - Otherwise go to ISSUE.
- **ISSUE:** eng_start = 1 for exactly one cycle, eng_op/eng_a/eng_b driven from the latch. Next state is WAIT.
- **WAIT:** hold eng_* operands. On eng_done, capture eng_hi/eng_lo into the result register and the cache, set cache_valid, go to RESP.
- **RESP:**
  - rsp_valid[id] = 1 for one cycle, with rsp_hi/rsp_lo = the result register. rsp_hi/rsp_lo hold their value outside RESP.
  - Update last_gnt = id, then go to IDLE.
- Requests are sampled only in IDLE.
  - A port still asserting req in the first IDLE cycle after its response issues a new request; with unchanged operands this is a cache hit.
  - If req drops mid-operation, the operation still completes and the response still pulses. Abort is not supported.
- eng_done outside WAIT is ignored.
- Reset behaviour:
  - Reset returns to IDLE, clears cache_valid, sets last_gnt = 1.
  - Outputs at reset: rsp_valid* = 0, rsp_hi = rsp_lo = 0, eng_start = 0, eng_op = 0, eng_a = eng_b = 0, busy = 0.
  - Reset mid-WAIT abandons the operation with no response. The engine is reset by the same rst.

## Timing
- Let T be the IDLE cycle in which the granted req is sampled.
- Cache hit or divide-by-zero: RESP in cycle T+1; rsp_valid high in T+1.
- Engine path:
  - ISSUE in T+1 (eng_start high).
  - With eng_done in cycle D, RESP is in D+1 and rsp_valid is high in D+1.
  - For an engine that pulses done N cycles after start, latency req→rsp_valid = N+2 cycles.
- Back-to-back: after RESP at cycle R, the next grant is sampled at R+1. The minimum spacing between responses is 2 cycles.
- All outputs are registered. There is no combinational path from req*/eng_done to any output.

## Structure
- Package muldiv_pkg holds:
  - op encoding: OP_MUL = 0, OP_DIV = 1
  - FSM state enum: IDLE, ISSUE, WAIT, RESP
  - DIV0_LO = all ones
  - default W
- Sub-module rr_arbiter2:
  - Two-way round-robin picker: inputs req[1:0] and last_gnt, outputs gnt_id and any.
  - Purely combinational; last_gnt is held in the parent.
- Cache (op, a, b, hi, lo, valid) and the operand/result latches live in the parent.

## Test plan
- Single MULT: port 0 a = 7, b = −3, engine model N = 33 → one eng_start, rsp_valid0 at T+35, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV by zero: port 1 a = 0x1234, b = 0 → no eng_start, rsp_valid1 at T+1, hi = 0x1234, lo = 0xFFFFFFFF.
- Cache hit:
  - DIV a = −17, b = 5 → hi = −2, lo = −3.
  - Same tuple reissued → rsp at T+1, no eng_start.
  - Then b = 6 → engine started.
- Contention: req0 and req1 both asserted from reset → port 0 served first, port 1 next. Port 0 re-requesting immediately still loses to a pending port 1 (alternation over 4 ops).
- Reset mid-WAIT: rst pulsed 10 cycles after eng_start → no rsp_valid, busy = 0 next cycle. A following identical request starts the engine (cache cleared).
- Spurious eng_done in IDLE → ignored; no rsp_valid, state stays IDLE.
